// File: rtl/btn_debounce_if.sv
// Event handshake between the debouncer's event FIFO and its consumer.
// The FIFO side drives valid/data, the consumer drives ready.
interface btn_debounce_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [3:0] evt_data;

  modport master (
    output evt_valid,
    output evt_data,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_data,
    output evt_ready
  );
endinterface

// File: rtl/btn_debounce.sv
// Eight-button debouncer: 2-FF synchronizers, tick-based stability counters,
// press/release pulses, a priority key encoder and a 4-deep event FIFO
// (first-word fall-through) fed by a lowest-index-first serializer.
module btn_debounce #(
  parameter int TICK_DIV     = 48000,
  parameter int STABLE_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] btn_n,
  input  logic       ovf_clr,
  btn_debounce_if.master evt,
  output logic [7:0] btn_clean_n,
  output logic [7:0] press_pulse,
  output logic [7:0] release_pulse,
  output logic       key_valid,
  output logic [2:0] key_idx,
  output logic       evt_ovf
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [PW-1:0] PS_LAST  = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [7:0]          sync1_q, sync2_q;
  logic [PW-1:0]       ps_q, ps_d;
  logic                tick;
  logic [7:0][CW-1:0]  cnt_q, cnt_d;
  logic [7:0]          clean_q, clean_d;
  logic [7:0]          flip;
  logic [7:0]          press_q, press_d;
  logic [7:0]          release_q, release_d;
  logic [7:0]          pending_q, pending_d;
  logic [7:0]          ptype_q, ptype_d;
  logic                ovf_q, ovf_d, ovf_set;
  logic [2:0]          mv_idx;
  logic [7:0]          mv_mask;
  logic                push, pop;
  logic [1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2:0]          count_q, count_d;
  logic [3:0]          mem_q [4];

  // Prescaler: one-cycle tick every TICK_DIV clocks.
  always_comb begin
    tick = (ps_q == PS_LAST);
    ps_d = tick ? '0 : ps_q + PW'(1);
  end

  // Per-button stability counters; a level must differ for a full run of ticks to flip.
  always_comb begin
    clean_d = clean_q;
    flip    = '0;
    cnt_d   = cnt_q;
    for (int i = 0; i < 8; i++) begin
      if (sync2_q[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i]   = '0;
          clean_d[i] = ~clean_q[i];
          flip[i]    = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    // Pulses are registered alongside the clean level so they line up with it.
    press_d   = flip & ~clean_d;
    release_d = flip & clean_d;
  end

  // Serializer: lowest-index pending event moves into the FIFO when it has room.
  always_comb begin
    mv_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pending_q[i]) mv_idx = 3'(i);
    end
    push    = (|pending_q) && (count_q < 3'd4);
    mv_mask = push ? (8'd1 << mv_idx) : 8'd0;
    // A flip on a button whose previous event is still waiting overwrites it.
    ovf_set   = |(flip & pending_q & ~mv_mask);
    pending_d = (pending_q & ~mv_mask) | flip;
    ptype_d   = (ptype_q & ~flip) | (flip & ~clean_d);
    ovf_d     = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  // FIFO pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
  always_comb begin
    pop     = (count_q != 3'd0) && evt.evt_ready;
    wptr_d  = push ? wptr_q + 2'd1 : wptr_q;
    rptr_d  = pop  ? rptr_q + 2'd1 : rptr_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 3'd1;
    else if (!push && pop) count_d = count_q - 3'd1;
  end

  // All control state; reset discards in-flight debounce and queued events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      ps_q      <= '0;
      cnt_q     <= '0;
      clean_q   <= '1;
      press_q   <= '0;
      release_q <= '0;
      pending_q <= '0;
      ptype_q   <= '0;
      ovf_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
    end else begin
      sync1_q   <= btn_n;
      sync2_q   <= sync1_q;
      ps_q      <= ps_d;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      press_q   <= press_d;
      release_q <= release_d;
      pending_q <= pending_d;
      ptype_q   <= ptype_d;
      ovf_q     <= ovf_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage: data only, validity comes from the count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {ptype_q[mv_idx], mv_idx};
  end

  // Key encoder: highest pressed index wins, matching the tone stage.
  always_comb begin
    key_valid = ~&clean_q;
    key_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!clean_q[i]) key_idx = 3'(i);
    end
  end

  assign btn_clean_n   = clean_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign evt_ovf       = ovf_q;
  assign evt.evt_valid = (count_q != 3'd0);
  assign evt.evt_data  = mem_q[rptr_q];

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with a queue scoreboard on the event port.
module tb_btn_debounce;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] btn_n;
  logic       ovf_clr;
  logic [7:0] btn_clean_n, press_pulse, release_pulse;
  logic       key_valid;
  logic [2:0] key_idx;
  logic       evt_ovf;

  btn_debounce_if evt_if ();

  btn_debounce #(
    .TICK_DIV     (TICK_DIV),
    .STABLE_TICKS (STABLE_TICKS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_n         (btn_n),
    .ovf_clr       (ovf_clr),
    .evt           (evt_if.master),
    .btn_clean_n   (btn_clean_n),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .key_valid     (key_valid),
    .key_idx       (key_idx),
    .evt_ovf       (evt_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clean(input logic [7:0] tgt, input string tag, output int n);
    n = 0;
    while (btn_clean_n !== tgt && n < 40) begin
      nxt();
      n++;
    end
    chk(tag, 32'(btn_clean_n), 32'(tgt));
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    evt_if.evt_ready = 1'b1;
    while (exp_q.size() != 0 && n < 60) begin
      nxt();
      n++;
    end
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    evt_if.evt_ready = 1'b0;
    nxt();
    chk({tag, "_empty"}, 32'(evt_if.evt_valid), 32'd0);
  endtask

  // Scoreboard: every accepted event is compared with the oldest expectation.
  always @(negedge clk) begin
    logic [4:0] e;
    if (rst_n === 1'b1 && evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else                   e = 5'h1F;
      chk("evt_data", 32'({1'b0, evt_if.evt_data}), 32'(e));
    end
  end

  initial begin
    int n;
    rst_n            = 1'b0;
    btn_n            = 8'hFF;
    ovf_clr          = 1'b0;
    evt_if.evt_ready = 1'b0;

    // Reset state and 50 idle cycles.
    nxt(); nxt(); nxt();
    chk("rst_state", 32'({btn_clean_n, press_pulse, release_pulse, key_valid, key_idx, evt_if.evt_valid, evt_ovf}),
        32'({8'hFF, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0}));
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      nxt();
      chk("idle", 32'({btn_clean_n, key_valid, evt_if.evt_valid, evt_ovf}), 32'({8'hFF, 3'b000}));
    end

    // Single press of button 2, then its release.
    btn_n = 8'hFB;
    exp_q.push_back(5'h0A);
    wait_clean(8'hFB, "press2_clean", n);
    chk("press2_latency", 32'(n >= 11 && n <= 14), 32'd1);
    chk("press2_pulse", 32'(press_pulse), 32'h04);
    nxt();
    chk("press2_pulse_end", 32'(press_pulse), 32'h00);
    chk("press2_key", 32'({key_valid, key_idx}), 32'({1'b1, 3'd2}));
    chk("press2_evt", 32'({evt_if.evt_valid, evt_if.evt_data}), 32'({1'b1, 4'hA}));
    drain("press2");
    btn_n = 8'hFF;
    exp_q.push_back(5'h02);
    wait_clean(8'hFF, "rel2_clean", n);
    chk("rel2_pulse", 32'(release_pulse), 32'h04);
    chk("rel2_key", 32'({key_valid, key_idx}), 32'({1'b0, 3'd0}));
    drain("rel2");

    // Short glitch on button 0 must be rejected.
    btn_n = 8'hFE;
    for (int i = 0; i < 40; i++) begin
      if (i == 6) btn_n = 8'hFF;
      nxt();
      chk("glitch", 32'({btn_clean_n, press_pulse, evt_if.evt_valid}), 32'({8'hFF, 8'h00, 1'b0}));
    end

    // Buttons 1 and 6 together with the consumer stalled.
    btn_n = 8'hBD;
    exp_q.push_back(5'h09);
    exp_q.push_back(5'h0E);
    wait_clean(8'hBD, "p16_clean", n);
    chk("p16_key", 32'({key_valid, key_idx}), 32'({1'b1, 3'd6}));
    nxt(); nxt(); nxt();
    for (int i = 0; i < 5; i++) begin
      chk("p16_stall", 32'({evt_if.evt_valid, evt_if.evt_data}), 32'({1'b1, 4'h9}));
      nxt();
    end
    drain("p16");
    btn_n = 8'hFF;
    exp_q.push_back(5'h01);
    exp_q.push_back(5'h06);
    wait_clean(8'hFF, "r16_clean", n);
    drain("r16");
    chk("r16_ovf", 32'(evt_ovf), 32'd0);

    // All buttons: press events for 4..7 are overwritten by their releases.
    btn_n = 8'h00;
    for (int i = 8; i < 12; i++) exp_q.push_back(5'(i));
    wait_clean(8'h00, "all_press_clean", n);
    chk("all_key", 32'({key_valid, key_idx}), 32'({1'b1, 3'd7}));
    nxt(); nxt(); nxt(); nxt(); nxt();
    btn_n = 8'hFF;
    for (int i = 0; i < 8; i++) exp_q.push_back(5'(i));
    wait_clean(8'hFF, "all_rel_clean", n);
    nxt();
    chk("all_ovf_set", 32'(evt_ovf), 32'd1);
    drain("all");
    chk("all_ovf_sticky", 32'(evt_ovf), 32'd1);
    ovf_clr = 1'b1;
    nxt();
    ovf_clr = 1'b0;
    chk("all_ovf_clr", 32'(evt_ovf), 32'd0);

    // Reset mid-debounce with two events queued.
    btn_n = 8'hD7;
    exp_q.push_back(5'h0B);
    exp_q.push_back(5'h0D);
    wait_clean(8'hD7, "q2_clean", n);
    nxt(); nxt(); nxt();
    chk("q2_queued", 32'(evt_if.evt_valid), 32'd1);
    btn_n = 8'hF7;
    for (int i = 0; i < 5; i++) nxt();
    rst_n = 1'b0;
    #1;
    chk("async_rst", 32'({btn_clean_n, press_pulse, release_pulse, key_valid, key_idx, evt_if.evt_valid, evt_ovf}),
        32'({8'hFF, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0}));
    exp_q.delete();
    exp_q.push_back(5'h0B);
    nxt(); nxt(); nxt();
    rst_n = 1'b1;
    wait_clean(8'hF7, "rerun_clean", n);
    chk("rerun_latency", 32'(n >= 11 && n <= 14), 32'd1);
    nxt();
    drain("rerun");
    for (int i = 0; i < 30; i++) nxt();
    chk("rerun_quiet", 32'({btn_clean_n, evt_if.evt_valid}), 32'({8'hF7, 1'b0}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
